im_loader: RTL and testbench

- Writer side of the instruction memory that the fetch unit reads.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then big-endian 32-bit instruction words.
- Writes each word into consecutive IM word slots starting at index 0, which is PC 0x0000_3000.
- Holds the CPU in reset until the image is fully written, then releases it.

---
 rtl/im_loader_pkg.sv | 23 ++
 rtl/im_loader_word_assembler.sv | 37 +++
 rtl/im_loader.sv | 108 ++++++++++
 tb/tb_im_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared IM geometry and loader state encoding
package im_loader_pkg;

    localparam int          IM_DEPTH   = 1024;
    localparam int          IM_AW      = 10;
    localparam logic [31:0] IM_BASE_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    // Word index used by the fetch side for a given PC (pc[11:2] for the default size).
    function automatic logic [IM_AW-1:0] im_index(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - IM_BASE_PC;
        return off[IM_AW+1:2];
    endfunction

endpackage

// File: rtl/im_loader_word_assembler.sv
// rtl/im_loader_word_assembler.sv - big-endian byte-to-word assembler with registered word_ready
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] sreg;

    assign last_byte = (byte_idx == 2'd3);

    // word only changes on completion, so it holds its value between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            sreg       <= 24'd0;
            word_ready <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_ready <= 1'b0;
            if (shift_en) begin
                byte_idx <= byte_idx + 2'd1;
                sreg     <= {sreg[15:0], byte_data};
                if (last_byte) begin
                    word       <= {sreg, byte_data};
                    word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - loads a counted big-endian word image into IM, then releases the CPU
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH = IM_DEPTH,
    parameter int AW    = IM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    state_t      next_state;
    logic [15:0] total;
    logic [AW:0] word_cnt;
    logic [15:0] hdr_count;
    logic        accept;
    logic        shift_en;
    logic        last_byte;
    logic        last_word;

    assign hdr_count = {total[15:8], byte_data};
    assign accept    = byte_valid && byte_ready;
    assign shift_en  = accept && (state == DATA);
    assign last_word = (16'(word_cnt) == (total - 16'd1));

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .byte_data  (byte_data),
        .last_byte  (last_byte),
        .word_ready (im_we),
        .word       (im_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_HI;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        case (state)
            HDR_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) next_state = HDR_LO;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (hdr_count == 16'd0)
                        next_state = DONE;
                    else if ({1'b0, hdr_count} > DEPTH_W)
                        next_state = ERR;
                    else
                        next_state = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                // leave on the edge that completes the final word, which is the edge raising im_we
                if (byte_valid && last_byte && last_word) next_state = DONE;
            end
            DONE:    next_state = DONE;
            ERR:     next_state = ERR;
            default: next_state = HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total     <= 16'd0;
            word_cnt  <= '0;
            im_addr   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            if (accept && state == HDR_HI) total[15:8] <= byte_data;
            if (accept && state == HDR_LO) total[7:0]  <= byte_data;
            if (shift_en && last_byte) begin
                im_addr  <= word_cnt[AW-1:0];
                word_cnt <= word_cnt + {{AW{1'b0}}, 1'b1};
            end
            if (state == DONE) done <= 1'b1;
            if (state == ERR)  err  <= 1'b1;
            // release lags done by a cycle so the final IM write has settled
            cpu_reset <= ~done;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized self-checking bench for im_loader
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int DEPTH = IM_DEPTH;
    localparam int AW    = IM_AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_reset;
    logic          done;
    logic          err;

    im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // write monitor: {addr, data} per im_we, plus event cycle markers
    logic [41:0] got_q[$];
    int   we_cyc    = -1;
    int   done_cyc  = -1;
    int   rel_cyc   = -1;
    int   back2back = 0;
    logic prev_we   = 1'b0;

    always @(negedge clk) begin
        if (im_we) begin
            got_q.push_back({im_addr, im_wdata});
            we_cyc = cyc;
            if (prev_we) back2back++;
        end
        prev_we = im_we;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (!cpu_reset && rel_cyc < 0) rel_cyc = cyc;
    end

    // reference model: what a correct loader does with a byte list
    logic [41:0] exp_q[$];
    int exp_acc;
    bit exp_done;
    bit exp_err;

    task automatic model(input logic [7:0] b[$]);
        int n;
        int cnt;
        n = b.size();
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        if (n < 2) begin
            exp_acc = n;
        end else begin
            cnt = int'({b[0], b[1]});
            if (cnt == 0) begin
                exp_acc  = 2;
                exp_done = 1;
            end else if (cnt > DEPTH) begin
                exp_acc = 2;
                exp_err = 1;
            end else begin
                for (int i = 0; i < cnt && (5 + 4 * i) < n; i++)
                    exp_q.push_back({AW'(i), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
                exp_done = (n >= 2 + 4 * cnt);
                exp_acc  = exp_done ? 2 + 4 * cnt : n;
            end
        end
    endtask

    int last_acc = -1;

    task automatic send(input logic [7:0] b[$], input bit gaps, input int budget, output int nacc);
        int i;
        i    = 0;
        nacc = 0;
        for (int c = 0; c < budget && i < b.size(); c++) begin
            @(negedge clk);
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = b[i];
            #1;
            if (byte_valid && byte_ready) begin
                i++;
                nacc++;
                last_acc = cyc + 1;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        got_q.delete();
        we_cyc    = -1;
        done_cyc  = -1;
        rel_cyc   = -1;
        back2back = 0;
        reset     = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] b[$], input bit gaps, input int budget);
        int nacc;
        model(b);
        send(b, gaps, budget, nacc);
        repeat (4) @(negedge clk);
        check({tag, ".accepted"}, 64'(nacc), 64'(exp_acc));
        check({tag, ".nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s.write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, ".done"}, 64'(done), 64'(exp_done));
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
        check({tag, ".byte_ready"}, 64'(byte_ready), 64'(!(exp_done || exp_err)));
        check({tag, ".we_b2b"}, 64'(back2back), 64'd0);
    endtask

    initial begin
        logic [7:0]  b[$];
        logic [41:0] last_wr;
        int          cnt;

        do_reset();
        check("rst.byte_ready", 64'(byte_ready), 64'd1);
        check("rst.im_we", 64'(im_we), 64'd0);
        check("rst.im_addr", 64'(im_addr), 64'd0);
        check("rst.im_wdata", 64'(im_wdata), 64'd0);
        check("rst.cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err", 64'(err), 64'd0);

        b = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0C};
        run("basic", b, 1'b0, 40);
        check("basic.we_latency", 64'(we_cyc), 64'(last_acc));
        check("basic.done_latency", 64'(done_cyc), 64'(we_cyc + 1));
        check("basic.rel_latency", 64'(rel_cyc), 64'(done_cyc + 1));

        do_reset();
        b = {8'h00, 8'h00};
        run("empty", b, 1'b0, 10);
        check("empty.done_latency", 64'(done_cyc), 64'(last_acc + 1));
        check("empty.rel_latency", 64'(rel_cyc), 64'(last_acc + 2));

        do_reset();
        b = {8'h04, 8'h01};
        for (int i = 0; i < 100; i++) b.push_back(8'($urandom));
        run("over", b, 1'b0, 102);

        do_reset();
        b = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run("gaps", b, 1'b1, 200);

        do_reset();
        b = {8'h00, 8'h03};
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        run("partial", b, 1'b0, 20);
        do_reset();
        b = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run("after_rst", b, 1'b0, 20);

        for (int k = 0; k < 4; k++) begin
            do_reset();
            cnt = int'($urandom_range(1, 10));
            b = {8'h00, 8'(cnt)};
            for (int i = 0; i < 4 * cnt; i++) b.push_back(8'($urandom));
            run($sformatf("rand%0d", k), b, 1'b1, 400);
        end

        do_reset();
        b = {8'h04, 8'h00};
        for (int i = 0; i < 4 * DEPTH + 8; i++) b.push_back(8'($urandom));
        run("full", b, 1'b0, 4 * DEPTH + 10);
        if (got_q.size() > 0) begin
            last_wr = got_q[got_q.size() - 1];
            check("full.last_addr", 64'(last_wr[41:32]), 64'(DEPTH - 1));
        end else begin
            check("full.any_write", 64'(got_q.size()), 64'(DEPTH));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
